// File: rtl/display_pkg.sv
// Shared 640x480p60 timing constants and fetch FSM state type for the display controller.
package display_pkg;

    localparam int DISP_CORDW   = 10;
    localparam int DISP_H_RES   = 640;
    localparam int DISP_H_FP    = 16;
    localparam int DISP_H_SYNC  = 96;
    localparam int DISP_H_BP    = 48;
    localparam int DISP_V_RES   = 480;
    localparam int DISP_V_FP    = 10;
    localparam int DISP_V_SYNC  = 2;
    localparam int DISP_V_BP    = 33;
    localparam bit DISP_SYNC_POL = 1'b0;

    localparam int DISP_H_TOTAL = DISP_H_RES + DISP_H_FP + DISP_H_SYNC + DISP_H_BP;
    localparam int DISP_V_TOTAL = DISP_V_RES + DISP_V_FP + DISP_V_SYNC + DISP_V_BP;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        READY = 2'd2
    } fetch_state_t;

    // Inclusive window test used for the sync pulse ranges.
    function automatic logic in_span(input int unsigned v, input int unsigned lo,
                                     input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/display_480p_ctrl_if.sv
// Video/fetch bundle between the timing controller and its consumers.
// Carries underflow_cnt only when DISPLAY_UNDERFLOW_CNT_EN is defined.
interface display_480p_ctrl_if #(
    parameter int CORDW = 10
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             frame;
    logic             line_req;
    logic [CORDW-1:0] line_y;
    logic             line_ack;
    logic             underflow;
`ifdef DISPLAY_UNDERFLOW_CNT_EN
    logic [15:0]      underflow_cnt;
`endif

    modport master (
        output sx, sy, hsync, vsync, de, frame, line_req, line_y, underflow,
`ifdef DISPLAY_UNDERFLOW_CNT_EN
        output underflow_cnt,
`endif
        input  line_ack
    );

    modport slave (
        input  sx, sy, hsync, vsync, de, frame, line_req, line_y, underflow,
`ifdef DISPLAY_UNDERFLOW_CNT_EN
        input  underflow_cnt,
`endif
        output line_ack
    );
endinterface

// File: rtl/display_fetch_fsm.sv
// Per-line fetch handshake: asks for the next active line during horizontal
// blanking and flags an underflow when the ack misses the end of the line.
module display_fetch_fsm
    import display_pkg::*;
#(
    parameter int CORDW   = DISP_CORDW,
    parameter int H_RES   = DISP_H_RES,
    parameter int H_TOTAL = DISP_H_TOTAL,
    parameter int V_RES   = DISP_V_RES,
    parameter int V_TOTAL = DISP_V_TOTAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CORDW-1:0] sx_i,
    input  logic [CORDW-1:0] sy_i,
    input  logic [CORDW-1:0] next_sy_i,
    input  logic             line_ack_i,
    output logic             line_req_o,
    output logic [CORDW-1:0] line_y_o,
    output logic             underflow_o
);

    localparam logic [CORDW-1:0] H_RES_C  = CORDW'(H_RES);
    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] V_RES_M1 = CORDW'(V_RES - 1);

    fetch_state_t     state_q, state_d;
    logic             line_req_q, line_req_d;
    logic [CORDW-1:0] line_y_q, line_y_d;
    logic             underflow_q, underflow_d;
    logic             fetch_line_s;
    logic             deadline_s;

    // Next-state, request line number and underflow decode.
    always_comb begin
        state_d      = state_q;
        line_y_d     = line_y_q;
        underflow_d  = 1'b0;
        // Next line is active when we are on the last line (wraps to 0) or below V_RES-1.
        fetch_line_s = (sy_i == V_LAST) || (sy_i < V_RES_M1);
        deadline_s   = (sx_i == H_LAST);
        case (state_q)
            IDLE: begin
                if ((sx_i == H_RES_C) && fetch_line_s) begin
                    state_d  = REQ;
                    line_y_d = next_sy_i;
                end else begin
                    state_d  = IDLE;
                end
            end
            REQ: begin
                // An ack on the deadline cycle still counts, and must not leave us in READY.
                if (line_ack_i) begin
                    state_d = deadline_s ? IDLE : READY;
                end else if (deadline_s) begin
                    state_d     = IDLE;
                    underflow_d = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            READY: begin
                if (deadline_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        line_req_d = (state_d == REQ);
    end

    // State and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            line_req_q  <= 1'b0;
            line_y_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_req_q  <= line_req_d;
            line_y_q    <= line_y_d;
            underflow_q <= underflow_d;
        end
    end

    assign line_req_o  = line_req_q;
    assign line_y_o    = line_y_q;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/display_480p_ctrl.sv
// 640x480p60 timing controller: screen counters, syncs, data enable, frame strobe
// and line fetch handshake. DISPLAY_UNDERFLOW_CNT_EN adds a saturating underflow counter.
module display_480p_ctrl
    import display_pkg::*;
#(
    parameter int CORDW    = DISP_CORDW,
    parameter int H_RES    = DISP_H_RES,
    parameter int H_FP     = DISP_H_FP,
    parameter int H_SYNC   = DISP_H_SYNC,
    parameter int H_BP     = DISP_H_BP,
    parameter int V_RES    = DISP_V_RES,
    parameter int V_FP     = DISP_V_FP,
    parameter int V_SYNC   = DISP_V_SYNC,
    parameter int V_BP     = DISP_V_BP,
    parameter bit SYNC_POL = DISP_SYNC_POL
) (
    input  logic                clk_pix,
    input  logic                rst,
    input  logic                clk_pix_locked,
    display_480p_ctrl_if.master vid
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_LAST  = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST  = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_RES_C = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_RES_C = CORDW'(V_RES);
    localparam int unsigned HS_START = H_RES + H_FP;
    localparam int unsigned HS_END   = H_RES + H_FP + H_SYNC - 1;
    localparam int unsigned VS_START = V_RES + V_FP;
    localparam int unsigned VS_END   = V_RES + V_FP + V_SYNC - 1;

    // Losing pixel clock lock is treated exactly like reset.
    logic hold_s;
    assign hold_s = rst | ~clk_pix_locked;

    logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d, next_sy_s;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             de_q, de_d, frame_q, frame_d;
    logic             line_req_s, underflow_s;
    logic [CORDW-1:0] line_y_s;

    // Counter advance and sync/enable decode from the current position.
    always_comb begin
        next_sy_s = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
        if (sx_q == H_LAST) begin
            sx_d = '0;
            sy_d = next_sy_s;
        end else begin
            sx_d = sx_q + 1'b1;
            sy_d = sy_q;
        end
        hsync_d = in_span(32'(sx_q), HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d = in_span(32'(sy_q), VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
        de_d    = (sx_q < H_RES_C) && (sy_q < V_RES_C);
        frame_d = (sx_q == '0) && (sy_q == '0);
    end

    // Counters plus the one-cycle-late video timing outputs.
    always_ff @(posedge clk_pix) begin
        if (hold_s) begin
            sx_q    <= '0;
            sy_q    <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            frame_q <= frame_d;
        end
    end

    display_fetch_fsm #(
        .CORDW   (CORDW),
        .H_RES   (H_RES),
        .H_TOTAL (H_TOTAL),
        .V_RES   (V_RES),
        .V_TOTAL (V_TOTAL)
    ) u_fetch (
        .clk         (clk_pix),
        .rst         (hold_s),
        .sx_i        (sx_q),
        .sy_i        (sy_q),
        .next_sy_i   (next_sy_s),
        .line_ack_i  (vid.line_ack),
        .line_req_o  (line_req_s),
        .line_y_o    (line_y_s),
        .underflow_o (underflow_s)
    );

    assign vid.sx        = sx_q;
    assign vid.sy        = sy_q;
    assign vid.hsync     = hsync_q;
    assign vid.vsync     = vsync_q;
    assign vid.de        = de_q;
    assign vid.frame     = frame_q;
    assign vid.line_req  = line_req_s;
    assign vid.line_y    = line_y_s;
    assign vid.underflow = underflow_s;

`ifdef DISPLAY_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    // Saturating count of underflow pulses.
    always_comb begin
        if (underflow_s && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end else begin
            uf_cnt_d = uf_cnt_q;
        end
    end

    // Only a real reset clears the count; lock loss keeps the history.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            uf_cnt_q <= 16'd0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign vid.underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_display_480p_ctrl.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor compares them.
module tb_display_480p_ctrl;
    import display_pkg::*;

    localparam int S_SX = 0, S_SY = 1, S_HS = 2, S_VS = 3, S_DE = 4, S_FR = 5;
    localparam int S_REQ = 6, S_LY = 7, S_UF = 8, S_UC = 9;

    typedef struct {
        int cyc;
        int dut;
        int sel;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic lock;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    display_480p_ctrl_if #(.CORDW(10)) bus_m ();
    display_480p_ctrl_if #(.CORDW(10)) bus_s ();

    display_480p_ctrl dut_main (
        .clk_pix        (clk),
        .rst            (rst),
        .clk_pix_locked (lock),
        .vid            (bus_m)
    );

    // Shrunk geometry so whole frames fit in a short run.
    display_480p_ctrl #(
        .CORDW(10), .H_RES(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_RES(12), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
    ) dut_small (
        .clk_pix        (clk),
        .rst            (rst),
        .clk_pix_locked (lock),
        .vid            (bus_s)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sel_name(input int s);
        case (s)
            S_SX: return "sx";
            S_SY: return "sy";
            S_HS: return "hsync";
            S_VS: return "vsync";
            S_DE: return "de";
            S_FR: return "frame";
            S_REQ: return "line_req";
            S_LY: return "line_y";
            S_UF: return "underflow";
            S_UC: return "underflow_cnt";
            default: return "unknown";
        endcase
    endfunction

    function automatic int sample(input int d, input int s);
        if (d == 0) begin
            case (s)
                S_SX: return int'(bus_m.sx);
                S_SY: return int'(bus_m.sy);
                S_HS: return int'(bus_m.hsync);
                S_VS: return int'(bus_m.vsync);
                S_DE: return int'(bus_m.de);
                S_FR: return int'(bus_m.frame);
                S_REQ: return int'(bus_m.line_req);
                S_LY: return int'(bus_m.line_y);
                S_UF: return int'(bus_m.underflow);
`ifdef DISPLAY_UNDERFLOW_CNT_EN
                S_UC: return int'(bus_m.underflow_cnt);
`endif
                default: return -1;
            endcase
        end else begin
            case (s)
                S_SX: return int'(bus_s.sx);
                S_SY: return int'(bus_s.sy);
                S_HS: return int'(bus_s.hsync);
                S_VS: return int'(bus_s.vsync);
                S_DE: return int'(bus_s.de);
                S_FR: return int'(bus_s.frame);
                S_REQ: return int'(bus_s.line_req);
                S_LY: return int'(bus_s.line_y);
                S_UF: return int'(bus_s.underflow);
                default: return -1;
            endcase
        end
    endfunction

    // Reference timing for k cycles after lock rises, with line_ack held high.
    function automatic int model(input int s, input int k, input int hr, input int hf,
                                 input int hs, input int hb, input int vr, input int vf,
                                 input int vs, input int vb);
        int ht, vt, psx, psy, nsy;
        ht = hr + hf + hs + hb;
        vt = vr + vf + vs + vb;
        if (s == S_SX) return k % ht;
        if (s == S_SY) return (k / ht) % vt;
        if (k == 0) begin
            if (s == S_HS || s == S_VS) return 1;
            return 0;
        end
        psx = (k - 1) % ht;
        psy = ((k - 1) / ht) % vt;
        nsy = (psy == vt - 1) ? 0 : psy + 1;
        case (s)
            S_HS: return (psx >= hr + hf && psx < hr + hf + hs) ? 0 : 1;
            S_VS: return (psy >= vr + vf && psy < vr + vf + vs) ? 0 : 1;
            S_DE: return (psx < hr && psy < vr) ? 1 : 0;
            S_FR: return (psx == 0 && psy == 0) ? 1 : 0;
            S_REQ: return (psx == hr && nsy < vr) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic push(input int c, input int d, input int s, input int v);
        exp_t e;
        e.cyc = c;
        e.dut = d;
        e.sel = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic push_reset(input int d, input int c);
        push(c, d, S_SX, 0);
        push(c, d, S_SY, 0);
        push(c, d, S_HS, 1);
        push(c, d, S_VS, 1);
        push(c, d, S_DE, 0);
        push(c, d, S_FR, 0);
        push(c, d, S_REQ, 0);
        push(c, d, S_LY, 0);
        push(c, d, S_UF, 0);
    endtask

    task automatic push_model(input int d, input int base, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            for (int s = S_SX; s <= S_UF; s++) begin
                if (s != S_LY) begin
                    if (d == 0) push(base + k, d, s, model(s, k, 640, 16, 96, 48, 480, 10, 2, 33));
                    else        push(base + k, d, s, model(s, k, 16, 2, 4, 2, 12, 2, 2, 2));
                end
            end
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                int got;
                got = sample(exp_q[i].dut, exp_q[i].sel);
                n_checks++;
                if (exp_q[i].cyc == cyc && got == exp_q[i].val) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s dut%0d cyc=%0d got=%0d exp=%0d (due cyc %0d)",
                             sel_name(exp_q[i].sel), exp_q[i].dut, cyc, got,
                             exp_q[i].val, exp_q[i].cyc);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        int base;
        int t;
        rst  = 1'b1;
        lock = 1'b0;
        bus_m.line_ack = 1'b1;
        bus_s.line_ack = 1'b1;

        push_reset(0, 2);
        push_reset(1, 2);
`ifdef DISPLAY_UNDERFLOW_CNT_EN
        push(2, 0, S_UC, 0);
`endif
        wait_cyc(4);
        rst = 1'b0;
        push_reset(0, 6);
        push_reset(1, 6);

        wait_cyc(8);
        n_checks++;
        if (bus_m.sx == 10'd0) n_pass++;
        else $display("FAIL lock-low sx dut0 got=%0d exp=0", bus_m.sx);
        n_checks++;
        if (bus_m.sy == 10'd0) n_pass++;
        else $display("FAIL lock-low sy dut0 got=%0d exp=0", bus_m.sy);
        n_checks++;
        if (bus_m.line_req == 1'b0) n_pass++;
        else $display("FAIL lock-low line_req dut0 got=%0d exp=0", bus_m.line_req);
        n_checks++;
        if (bus_m.underflow == 1'b0) n_pass++;
        else $display("FAIL lock-low underflow dut0 got=%0d exp=0", bus_m.underflow);
        n_checks++;
        if (bus_s.sx == 10'd0) n_pass++;
        else $display("FAIL lock-low sx dut1 got=%0d exp=0", bus_s.sx);
        lock = 1'b1;
        base = cyc;
        push_model(0, base, 1, 3);
        push_model(0, base, 800, 1601);
        push_model(1, base, 1, 440);

        // Successful fetch on line 10, ack five cycles after the request rises.
        t = base + 10 * 800;
        wait_cyc(t + 600);
        bus_m.line_ack = 1'b0;
        push(t + 640, 0, S_SY, 10);
        push(t + 640, 0, S_REQ, 0);
        for (int j = 641; j <= 646; j++) push(t + j, 0, S_REQ, 1);
        push(t + 641, 0, S_LY, 11);
        push(t + 647, 0, S_REQ, 0);
        push(t + 800, 0, S_UF, 0);
        push(t + 801, 0, S_UF, 0);
        wait_cyc(t + 646);
        bus_m.line_ack = 1'b1;

        // Line 20: no ack at all, so the deadline expires.
        t = base + 20 * 800;
        wait_cyc(t + 600);
        bus_m.line_ack = 1'b0;
        push(t + 641, 0, S_REQ, 1);
        push(t + 641, 0, S_LY, 21);
        push(t + 799, 0, S_REQ, 1);
        push(t + 799, 0, S_UF, 0);
        push(t + 800, 0, S_REQ, 0);
        push(t + 800, 0, S_UF, 1);
        push(t + 801, 0, S_UF, 0);
`ifdef DISPLAY_UNDERFLOW_CNT_EN
        push(t + 801, 0, S_UC, 1);
`endif
        // Line 21: ack lands exactly on the deadline cycle; line 22 must fetch normally.
        t = base + 21 * 800;
        push(t + 641, 0, S_REQ, 1);
        push(t + 641, 0, S_LY, 22);
        push(t + 800, 0, S_REQ, 0);
        push(t + 800, 0, S_UF, 0);
        push(t + 801, 0, S_UF, 0);
        push(t + 800 + 641, 0, S_REQ, 1);
        push(t + 800 + 641, 0, S_LY, 23);
        push(t + 800 + 642, 0, S_REQ, 0);
`ifdef DISPLAY_UNDERFLOW_CNT_EN
        push(t + 801, 0, S_UC, 1);
`endif
        wait_cyc(t + 799);
        bus_m.line_ack = 1'b1;

        // Line 23: reset pulse while the request is pending.
        t = base + 23 * 800;
        wait_cyc(t + 600);
        bus_m.line_ack = 1'b0;
        push(t + 641, 0, S_REQ, 1);
        wait_cyc(t + 700);
        rst = 1'b1;
        push(cyc + 1, 0, S_REQ, 0);
        push(cyc + 1, 0, S_SX, 0);
        push(cyc + 1, 0, S_SY, 0);
        push(cyc + 1, 0, S_LY, 0);
        push(cyc + 1, 0, S_UF, 0);
        push(cyc + 1, 0, S_HS, 1);
        push(cyc + 1, 0, S_DE, 0);
        wait_cyc(cyc + 1);
        rst = 1'b0;
        bus_m.line_ack = 1'b1;
        base = cyc;
        push(base + 1, 0, S_SX, 1);
        push(base + 2, 0, S_SX, 2);
        push(base + 2, 0, S_SY, 0);
        push(base + 1, 0, S_REQ, 0);
`ifdef DISPLAY_UNDERFLOW_CNT_EN
        push(base + 1, 0, S_UC, 0);
`endif
        wait_cyc(base + 10);

        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            $display("FAIL %s dut%0d never compared (due cyc %0d)",
                     sel_name(exp_q[i].sel), exp_q[i].dut, exp_q[i].cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
